// File: rtl/csr_ctrl.sv
// csr_ctrl: commit-stage sequencer for CSRRD/CSRWR/CSRXCHG, ERTN and exceptions.
// Define CSR_CTRL_INT_EN to let a pending interrupt pre-empt the request at IDLE.
`ifndef ECODE_ERTN
`define ECODE_ERTN 8'h3F
`endif

module csr_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [13:0] req_csr,
    input  logic [31:0] req_rd_data,
    input  logic [31:0] req_rj_data,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_pc,
    input  logic [7:0]  req_ecode,
    input  logic        req_esubcode,
    input  logic [31:0] req_vaddr,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        csr_re,
    output logic [13:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [13:0] csr_waddr,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    output logic        ex_en,
    output logic [7:0]  ecode,
    output logic        esubcode,
    output logic [31:0] pc,
    output logic [31:0] vaddr,
    output logic        ertn_flush,
    input  logic        has_int,
    input  logic [31:0] new_pc,
    input  logic [31:0] ex_entryPC
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_RESP, S_EXC, S_ERTN, S_REDIR
    } state_t;

    localparam logic [2:0] OP_RD   = 3'd0;
    localparam logic [2:0] OP_WR   = 3'd1;
    localparam logic [2:0] OP_XCHG = 3'd2;
    localparam logic [2:0] OP_ERTN = 3'd3;
    localparam logic [2:0] OP_EXC  = 3'd4;

    state_t      state;
    logic [2:0]  op_q;
    logic [13:0] csr_q;
    logic [31:0] rd_data_q;
    logic [31:0] rj_data_q;
    logic [4:0]  rd_q;
    logic [31:0] old_val;
    logic        int_take;

`ifdef CSR_CTRL_INT_EN
    assign int_take = has_int;
`else
    logic unused_has_int;
    assign unused_has_int = has_int;
    assign int_take       = 1'b0;
`endif

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= S_IDLE;
            req_ready      <= 1'b1;
            op_q           <= '0;
            csr_q          <= '0;
            rd_data_q      <= '0;
            rj_data_q      <= '0;
            rd_q           <= '0;
            old_val        <= '0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            csr_re         <= 1'b0;
            csr_raddr      <= '0;
            csr_we         <= 1'b0;
            csr_waddr      <= '0;
            csr_wmask      <= '0;
            csr_wdata      <= '0;
            ex_en          <= 1'b0;
            ecode          <= '0;
            esubcode       <= 1'b0;
            pc             <= '0;
            vaddr          <= '0;
            ertn_flush     <= 1'b0;
        end else begin
            // NOTE: every output is cleared here and re-asserted only for the state being entered,
            // which keeps each pulse exactly one cycle wide without separate clear logic.
            req_ready      <= 1'b0;
            wb_valid       <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            csr_re         <= 1'b0;
            csr_raddr      <= '0;
            csr_we         <= 1'b0;
            csr_waddr      <= '0;
            csr_wmask      <= '0;
            csr_wdata      <= '0;
            ex_en          <= 1'b0;
            ecode          <= '0;
            esubcode       <= 1'b0;
            pc             <= '0;
            vaddr          <= '0;
            ertn_flush     <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        csr_q     <= req_csr;
                        rd_data_q <= req_rd_data;
                        rj_data_q <= req_rj_data;
                        rd_q      <= req_rd;
                        if (int_take) begin
                            state <= S_EXC;
                            ex_en <= 1'b1;
                            pc    <= req_pc;
                        end else if (req_op == OP_EXC) begin
                            state    <= S_EXC;
                            ex_en    <= 1'b1;
                            ecode    <= req_ecode;
                            esubcode <= req_esubcode;
                            pc       <= req_pc;
                            vaddr    <= req_vaddr;
                        end else if (req_op == OP_ERTN) begin
                            state      <= S_ERTN;
                            ertn_flush <= 1'b1;
                            ecode      <= `ECODE_ERTN;
                        end else begin
                            state     <= S_READ;
                            csr_re    <= 1'b1;
                            csr_raddr <= req_csr;
                        end
                    end
                end
                S_READ: begin
                    old_val <= csr_rdata;
                    if (op_q == OP_WR || op_q == OP_XCHG) begin
                        state     <= S_WRITE;
                        csr_we    <= 1'b1;
                        csr_waddr <= csr_q;
                        csr_wdata <= rd_data_q;
                        csr_wmask <= (op_q == OP_WR) ? 32'hFFFF_FFFF : rj_data_q;
                    end else begin
                        // Op codes 5-7 read like CSRRD but never write back.
                        state    <= S_RESP;
                        wb_valid <= (op_q == OP_RD);
                        wb_rd    <= rd_q;
                        wb_data  <= csr_rdata;
                    end
                end
                S_WRITE: begin
                    state    <= S_RESP;
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= old_val;
                end
                S_EXC: begin
                    state          <= S_REDIR;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= ex_entryPC;
                end
                S_ERTN: begin
                    // new_pc is sampled on the same edge the CSR file applies the ertn update.
                    state          <= S_REDIR;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= new_pc;
                end
                S_RESP, S_REDIR: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// tb_csr_ctrl: randomized self-checking bench for csr_ctrl against a transaction-level model.
// Honors CSR_CTRL_INT_EN the same way the design does.
`ifndef ECODE_ERTN
`define ECODE_ERTN 8'h3F
`endif

module tb_csr_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [13:0] req_csr;
    logic [31:0] req_rd_data;
    logic [31:0] req_rj_data;
    logic [4:0]  req_rd;
    logic [31:0] req_pc;
    logic [7:0]  req_ecode;
    logic        req_esubcode;
    logic [31:0] req_vaddr;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        csr_re;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        ex_en;
    logic [7:0]  ecode;
    logic        esubcode;
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic        ertn_flush;
    logic        has_int;
    logic [31:0] new_pc;
    logic [31:0] ex_entryPC;

    int n_checks = 0;
    int n_fail   = 0;

    csr_ctrl dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
        .req_rd_data(req_rd_data), .req_rj_data(req_rj_data), .req_rd(req_rd), .req_pc(req_pc),
        .req_ecode(req_ecode), .req_esubcode(req_esubcode), .req_vaddr(req_vaddr),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
        .csr_re(csr_re), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .ex_en(ex_en), .ecode(ecode), .esubcode(esubcode), .pc(pc), .vaddr(vaddr),
        .ertn_flush(ertn_flush), .has_int(has_int), .new_pc(new_pc), .ex_entryPC(ex_entryPC)
    );

    always #5 clk = ~clk;

    // Power-on contents of the CSR file, shared by the emulated file and the model.
    function automatic logic [31:0] init_val(input logic [13:0] a);
        case (a)
            14'h30:  return 32'h1234_5678;
            14'h04:  return 32'h0000_0003;
            default: return ({18'h0, a} * 32'h9E37_79B1) ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Emulated CSR file: combinational read, masked write on the clock edge.
    logic [31:0] csr_file [16384];
    bit          written  [16384];

    function automatic logic [31:0] file_val(input logic [13:0] a);
        return written[a] ? csr_file[a] : init_val(a);
    endfunction

    assign csr_rdata = file_val(csr_raddr);

    always @(posedge clk) begin
        if (csr_we) begin
            csr_file[csr_waddr] <= (file_val(csr_waddr) & ~csr_wmask) | (csr_wdata & csr_wmask);
            written[csr_waddr]  <= 1'b1;
        end
    end

    // ERTN side effect: new_pc changes right after the flush edge.
    int          ertn_cnt = 0;
    int          ertn_base = 0;
    logic [31:0] new_pc_pre = '0;
    always @(posedge clk) if (ertn_flush) ertn_cnt <= ertn_cnt + 1;
    assign new_pc = (ertn_cnt == ertn_base) ? new_pc_pre : ~new_pc_pre;

    // Reference model: architectural CSR values after each completed operation.
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] ref_read(input logic [13:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] all_outputs();
        return {wb_valid, wb_rd, wb_data, redirect_valid, redirect_pc, busy, csr_re, csr_raddr,
                csr_we, csr_waddr, csr_wmask, csr_wdata, ex_en, ecode, esubcode, pc, vaddr,
                ertn_flush};
    endfunction

    task automatic scramble_inputs();
        req_op       = 3'($urandom);
        req_csr      = 14'($urandom);
        req_rd_data  = $urandom;
        req_rj_data  = $urandom;
        req_rd       = 5'($urandom);
        req_pc       = $urandom;
        req_ecode    = 8'($urandom);
        req_esubcode = 1'($urandom);
        req_vaddr    = $urandom;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [13:0] csr, input logic [31:0] wd,
                          input logic [31:0] mk, input logic [4:0] rd, input logic [31:0] pcv,
                          input logic [7:0] ec, input logic es, input logic [31:0] va,
                          input logic intr, input logic [31:0] entry, input logic [31:0] npc);
        logic        take_int;
        int          e_re, e_we, e_wb, e_ex, e_er, e_rdr, e_done;
        logic [31:0] e_old, e_mask, e_rpc, e_pc, e_va;
        logic [7:0]  e_ec;
        logic        e_es;
        int          g_re, g_we, g_wb, g_ex, g_er, g_rdr;
        int          n_re, n_we, n_wb, n_ex, n_er, n_rdr, stray;
        logic [13:0] g_raddr, g_waddr;
        logic [31:0] g_wmask, g_wdata, g_wbdata, g_rpc, g_pc, g_va;
        logic [4:0]  g_wbrd;
        logic [7:0]  g_ec;
        logic        g_es;
        logic        ready_at [1:6];

        take_int = 1'b0;
`ifdef CSR_CTRL_INT_EN
        take_int = intr;
`endif
        e_re = 0; e_we = 0; e_wb = 0; e_ex = 0; e_er = 0; e_rdr = 0; e_done = 2;
        e_old = '0; e_mask = '0; e_rpc = '0; e_pc = '0; e_va = '0; e_ec = '0; e_es = 1'b0;
        if (take_int || op == 3'd4) begin
            e_ex = 1; e_rdr = 2; e_rpc = entry; e_pc = pcv;
            e_ec = take_int ? 8'h00 : ec;
            e_es = take_int ? 1'b0 : es;
            e_va = take_int ? 32'h0 : va;
        end else if (op == 3'd3) begin
            e_er = 1; e_rdr = 2; e_rpc = npc;
        end else begin
            e_re  = 1;
            e_old = ref_read(csr);
            if (op == 3'd1 || op == 3'd2) begin
                e_mask = (op == 3'd1) ? 32'hFFFF_FFFF : mk;
                ref_mem[int'(csr)] = (e_old & ~e_mask) | (wd & e_mask);
                e_we = 2; e_wb = 3; e_done = 3;
            end else if (op == 3'd0) begin
                e_wb = 2;
            end
        end

        @(negedge clk);
        check("ready_before", req_ready, 1'b1);
        req_valid = 1'b1; req_op = op; req_csr = csr; req_rd_data = wd; req_rj_data = mk;
        req_rd = rd; req_pc = pcv; req_ecode = ec; req_esubcode = es; req_vaddr = va;
        has_int = intr; ex_entryPC = entry; new_pc_pre = npc; ertn_base = ertn_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        has_int   = 1'b0;
        scramble_inputs();

        g_re = 0; g_we = 0; g_wb = 0; g_ex = 0; g_er = 0; g_rdr = 0;
        n_re = 0; n_we = 0; n_wb = 0; n_ex = 0; n_er = 0; n_rdr = 0; stray = 0;
        g_raddr = '0; g_waddr = '0; g_wmask = '0; g_wdata = '0; g_wbdata = '0; g_rpc = '0;
        g_pc = '0; g_va = '0; g_wbrd = '0; g_ec = '0; g_es = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            ready_at[c] = req_ready;
            if (c == 1) check("busy_c1", busy, 1'b1);
            if (csr_re) begin n_re++; g_re = c; g_raddr = csr_raddr; end
            if (csr_we) begin
                n_we++; g_we = c; g_waddr = csr_waddr; g_wmask = csr_wmask; g_wdata = csr_wdata;
            end
            if (wb_valid) begin n_wb++; g_wb = c; g_wbrd = wb_rd; g_wbdata = wb_data; end
            if (ex_en) begin
                n_ex++; g_ex = c; g_ec = ecode; g_es = esubcode; g_pc = pc; g_va = vaddr;
            end
            if (ertn_flush) begin n_er++; g_er = c; g_ec = ecode; end
            if (redirect_valid) begin n_rdr++; g_rdr = c; g_rpc = redirect_pc; end
            if (!ex_en && !ertn_flush && ({ecode, esubcode, pc, vaddr} != '0)) stray++;
            if (!csr_we && csr_wmask != '0) stray++;
            if (!csr_re && csr_re != 1'b0) stray++;
        end

        check("re_cycle", g_re, e_re);       check("re_count", n_re, (e_re != 0));
        check("we_cycle", g_we, e_we);       check("we_count", n_we, (e_we != 0));
        check("wb_cycle", g_wb, e_wb);       check("wb_count", n_wb, (e_wb != 0));
        check("ex_cycle", g_ex, e_ex);       check("ex_count", n_ex, (e_ex != 0));
        check("ertn_cycle", g_er, e_er);     check("ertn_count", n_er, (e_er != 0));
        check("redir_cycle", g_rdr, e_rdr);  check("redir_count", n_rdr, (e_rdr != 0));
        check("stray_fields", stray, 0);
        check("ready_done", ready_at[e_done], 1'b0);
        check("ready_after", ready_at[e_done + 1], 1'b1);
        if (e_re != 0) check("raddr", g_raddr, csr);
        if (e_we != 0) begin
            check("waddr", g_waddr, csr);
            check("wmask", g_wmask, e_mask);
            check("wdata", g_wdata, wd);
        end
        if (e_wb != 0) begin
            check("wb_rd", g_wbrd, rd);
            check("wb_data", g_wbdata, e_old);
        end
        if (e_ex != 0) begin
            check("ex_ecode", g_ec, e_ec);
            check("ex_esub", g_es, e_es);
            check("ex_pc", g_pc, e_pc);
            check("ex_vaddr", g_va, e_va);
        end
        if (e_er != 0) check("ertn_ecode", g_ec, `ECODE_ERTN);
        if (e_rdr != 0) check("redir_pc", g_rpc, e_rpc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int quiet;
        logic [2:0]  op;
        logic [13:0] csr;

        rstn = 1'b0; req_valid = 1'b0; has_int = 1'b0; ex_entryPC = '0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", all_outputs(), '0);
        check("rst_ready", req_ready, 1'b1);
        rstn = 1'b1;

        run_op(3'd0, 14'h30, 32'h0, 32'h0, 5'd5, 32'h1C00_0000, 8'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        run_op(3'd2, 14'h04, 32'hFFFF_FFFF, 32'h0000_00F0, 5'd6, 32'h1C00_0004, 8'h0, 1'b0, 32'h0,
               1'b0, 32'h0, 32'h0);
        run_op(3'd0, 14'h04, 32'h0, 32'h0, 5'd7, 32'h1C00_0008, 8'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        run_op(3'd4, 14'h00, 32'h0, 32'h0, 5'd0, 32'h1C00_0100, 8'h0B, 1'b1, 32'hDEAD_0000, 1'b0,
               32'h1C00_8000, 32'h0);
        run_op(3'd3, 14'h00, 32'h0, 32'h0, 5'd0, 32'h1C00_0110, 8'h00, 1'b0, 32'h0, 1'b0,
               32'h0, 32'h1C00_0104);
        run_op(3'd1, 14'h05, 32'hABCD_0123, 32'h0, 5'd9, 32'h1C00_0200, 8'h0, 1'b0, 32'h0, 1'b1,
               32'h1C00_8000, 32'h0);
        run_op(3'd6, 14'h30, 32'h0, 32'h0, 5'd3, 32'h1C00_0300, 8'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        // Reset asserted while the write is on the CSR port.
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_csr = 14'h10; req_rd_data = 32'hDEAD_BEEF;
        req_rj_data = 32'h0; req_rd = 5'd7; has_int = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_we", csr_we, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs", all_outputs(), '0);
        check("rst_mid_ready", req_ready, 1'b1);
        rstn = 1'b1;
        ref_mem[int'(14'h10)] = 32'hDEAD_BEEF;
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid || redirect_valid || csr_we || csr_re || ex_en) quiet++;
        end
        check("rst_mid_quiet", quiet, 0);
        run_op(3'd0, 14'h10, 32'h0, 32'h0, 5'd1, 32'h1C00_0400, 8'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       csr = 14'h30;
                1:       csr = 14'h04;
                2:       csr = 14'h10;
                default: csr = 14'($urandom_range(0, 31));
            endcase
            run_op(op, csr, $urandom, $urandom, 5'($urandom), $urandom, 8'($urandom),
                   1'($urandom), $urandom, ($urandom_range(0, 5) == 0), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
